// File: rtl/rom_fetch_master.sv
// rom_fetch_master
//   Bus initiator that fetches one 32-bit word at a time from the instruction
//   ROM on behalf of the CPU fetch stage. A request accepted on the req port
//   produces a single-cycle cs/as strobe. The master then waits for rdy and
//   returns the word on the rsp port. If rdy does not arrive within TIMEOUT
//   wait cycles, it returns an error instead. A pipeline flush discards the
//   in-flight result.
//
// Ports
//   clk, rst        clock; asynchronous active-low reset
//   req_valid/ready fetch request handshake, req_addr = word address
//   flush           discard the current fetch (pipeline redirect)
//   rsp_valid/ready response handshake, rsp_data = word, rsp_err = timeout
//   bus_cs, bus_as  chip select / address strobe (always equal)
//   bus_addr        latched fetch address
//   bus_data        slave read data, valid with bus_rdy
//   bus_rdy         slave ready, one cycle after it samples cs&&as
module rom_fetch_master #(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15,
  parameter int TO_W    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              req_ready,
  input  logic              flush,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  input  logic              rsp_ready,
  output logic              bus_cs,
  output logic              bus_as,
  output logic [ADDR_W-1:0] bus_addr,
  input  logic [DATA_W-1:0] bus_data,
  input  logic              bus_rdy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_WAIT,
    S_RESP
  } state_t;

  localparam logic [TO_W-1:0] CNT_LAST = TO_W'(TIMEOUT - 1);

  state_t            r_state;
  logic              r_drop;
  logic [TO_W-1:0]   r_cnt;
  logic              r_req_ready;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_data;
  logic              r_rsp_err;
  logic              r_bus_cs;
  logic [ADDR_W-1:0] r_bus_addr;

  logic w_drop_now;
  logic w_timeout;
  logic w_done;

  // A flush in the same cycle as rdy/timeout must also suppress the response.
  assign w_drop_now = r_drop | flush;
  assign w_timeout  = (r_cnt == CNT_LAST);
  assign w_done     = bus_rdy | w_timeout;

  // ---- control FSM: all outputs are registered ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_drop      <= 1'b0;
      r_cnt       <= '0;
      r_req_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
      r_bus_cs    <= 1'b0;
      r_bus_addr  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // Stray bus_rdy is deliberately ignored here.
          if (r_req_ready && req_valid && !flush) begin
            r_bus_addr  <= req_addr;
            r_drop      <= 1'b0;
            r_cnt       <= '0;
            r_req_ready <= 1'b0;
            r_bus_cs    <= 1'b1;
            r_state     <= S_ADDR;
          end else begin
            // req_ready comes up one cycle after reset release.
            r_req_ready <= 1'b1;
          end
        end

        S_ADDR: begin
          // The strobe is already on the bus, so a flush can only mark the
          // result for discard.
          r_bus_cs <= 1'b0;
          r_cnt    <= '0;
          if (flush) r_drop <= 1'b1;
          r_state  <= S_WAIT;
        end

        S_WAIT: begin
          if (flush) r_drop <= 1'b1;
          // rdy takes priority over a timeout in the same cycle.
          if (bus_rdy) begin
            r_rsp_data <= bus_data;
            r_rsp_err  <= 1'b0;
          end else if (w_timeout) begin
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b1;
          end else begin
            // The counter stops at CNT_LAST because WAIT is always left there.
            r_cnt <= r_cnt + TO_W'(1);
          end
          if (w_done) begin
            if (w_drop_now) begin
              r_req_ready <= 1'b1;
              r_state     <= S_IDLE;
            end else begin
              r_rsp_valid <= 1'b1;
              r_state     <= S_RESP;
            end
          end
        end

        S_RESP: begin
          // flush and rsp_ready both retire the response; flush wins, but
          // both lead to the same next state.
          if (flush || rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= S_IDLE;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_err   = r_rsp_err;
  assign bus_cs    = r_bus_cs;
  assign bus_as    = r_bus_cs;
  assign bus_addr  = r_bus_addr;

endmodule
